hexagon_outline_gen: RTL and testbench
======================================

HEXAGON_OUTLINE_GEN -- requirements
Module: hexagon_outline_gen

Interface
REQ-001 Parameter HX_NUM, default 111; numerator of the half-width factor (hx = d*HX_NUM >> HX_SHIFT, ≈1.73d).
REQ-002 Parameter HX_SHIFT, default 6; right-shift applied to d*HX_NUM.
REQ-003 Port clk, input, 1; single clock, rising edge.
REQ-004 Port rst_n, input, 1; asynchronous, active-low reset.
REQ-005 Port start, input, 1; request one outline walk (sampled in IDLE only).
REQ-006 Port xcenter, input, 10; hexagon centre X.
REQ-007 Port ycenter, input, 10; hexagon centre Y.
REQ-008 Port d, input, 10; size unit (top vertex at ycenter+2d).
REQ-009 Port busy, output, 1; high from the cycle after start is accepted until the done cycle.
REQ-010 Port pix_valid, output, 1; pix_x/pix_y/pix_last are valid.
REQ-011 Port pix_ready, input, 1; consumer accepts the pixel.
REQ-012 Port pix_x, output, 10; outline pixel X.
REQ-013 Port pix_y, output, 10; outline pixel Y.
REQ-014 Port pix_last, output, 1; marks the final emitted pixel of the walk.
REQ-015 Port done, output, 1; one-cycle pulse at walk completion.

Function
REQ-016 In IDLE, start=1 latches xcenter, ycenter and d, sets busy, and enters LOAD; start is ignored when not in IDLE.
REQ-017 LOAD (1 cycle) computes vertices V0..V5 in 13-bit signed: V0 (xc,yc+2d), V1 (xc+hx,yc+d), V2 (xc+hx,yc-d), V3 (xc,yc-2d), V4 (xc-hx,yc-d), V5 (xc-hx,yc+d).
REQ-018 State sequence: IDLE -> LOAD -> SETUP -> STEP -> (SETUP for next edge | DONE) -> IDLE.
REQ-019 SETUP (1 cycle) loads the Bresenham state for edge k, from Vk to V(k+1 mod 6): |dx|, |dy|, step signs, error term.
REQ-020 STEP walks edge k from Vk inclusive to V(k+1) exclusive, one pixel per step, along the major axis (step count = max(|dx|,|dy|)).
REQ-021 A walked pixel with x or y outside 0..1023 is clipped: it is not emitted, and the walk advances one step per cycle.
REQ-022 An on-screen pixel is presented with pix_valid=1; pix_x, pix_y and pix_last stay stable until a cycle with pix_valid&&pix_ready; the walk advances in the cycle after that transfer.
REQ-023 pix_valid never deasserts without a transfer, except on reset.
REQ-024 pix_last=1 only on the final walked pixel of edge 5, and only if that pixel is on-screen.
REQ-025 d=0: exactly one pixel (xcenter,ycenter) is emitted with pix_last=1.
REQ-026 Zero-length edges emit nothing and go straight from SETUP to the next edge.
REQ-027 DONE asserts done for one cycle, deasserts busy, and returns to IDLE; start can be accepted in the cycle after done.
REQ-028 No pixel is emitted twice within a walk, and the outline is closed.

Reset
REQ-029 rst_n=0 immediately forces IDLE, busy=0, pix_valid=0, pix_last=0, done=0, pix_x=0, pix_y=0.
REQ-030 Reset mid-walk aborts the walk with no done pulse; the next walk needs a new start.

Structure
REQ-031 Shared package hex_pkg holds: the state enum (IDLE, LOAD, SETUP, STEP, DONE), COORD_W=13, and the defaults for HX_NUM and HX_SHIFT.
REQ-032 The per-edge Bresenham engine is sub-module line_stepper (load, advance, cur_x, cur_y, edge_end).

Verification
REQ-033 xc=100, yc=100, d=4, pix_ready=1 -> hx=6, exactly 40 pixels, first (100,108), last (99,107) with pix_last=1, then done pulse.
REQ-034 Same walk with pix_ready toggling randomly -> identical pixel sequence, and data stable while valid&&!ready.
REQ-035 d=0, xc=5, yc=7 -> single pixel (5,7) with pix_last=1, then done.
REQ-036 xc=2, yc=500, d=4 -> every emitted pix_x in 0..8, no wrap values, done pulses.
REQ-037 rst_n pulsed low after the 10th transfer of the REQ-033 walk -> outputs at reset values, no done; a new start then reproduces the full 40-pixel walk.
REQ-038 start held high through a walk -> a single walk runs, and the next walk starts only after done.

Source files
------------

// File: rtl/hex_pkg.sv
// hex_pkg -- shared definitions for the hexagon outline generator.
//
// Holds the walk state encoding, the internal signed coordinate width, the
// default half-width factor (hx = d*HX_NUM >> HX_SHIFT, roughly 1.73*d) and
// the helper that computes hx.
package hex_pkg;

    localparam int COORD_W      = 13;
    localparam int HX_NUM_DEF   = 111;
    localparam int HX_SHIFT_DEF = 6;

    // Signed working coordinate: vertices of a large hexagon near the screen
    // edge can fall below 0 or beyond 1023.
    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STEP,
        DONE
    } state_e;

    // Half-width of the hexagon for size unit d.
    function automatic coord_t half_width(input logic [9:0] d,
                                          input int         num,
                                          input int         shift);
        logic [31:0] prod;
        prod = 32'(d) * 32'(num);
        return coord_t'(prod >> shift);
    endfunction

endpackage

// File: rtl/line_stepper.sv
// line_stepper -- Bresenham engine for one straight edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture a new edge from (x0,y0) to (x1,y1)
//   advance           move one pixel along the edge (ignored at the end)
//   x0, y0, x1, y1    edge start (inclusive) and end (exclusive)
//   cur_x, cur_y      current walked pixel
//   edge_end          no pixels left on this edge (cur is the end point)
//   last_step         cur is the final pixel of the edge
//
// The step counter is loaded with max(|dx|,|dy|): the major axis moves on
// every advance, so the counter reaching zero coincides with arriving at the
// end point, which is excluded from this edge and emitted by the next one.
module line_stepper
    import hex_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   advance,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t cur_x,
    output coord_t cur_y,
    output logic   edge_end,
    output logic   last_step
);

    localparam int ERR_W = COORD_W + 3;
    typedef logic signed [ERR_W-1:0] err_t;

    localparam coord_t             C_ONE   = coord_t'(1);
    localparam logic [COORD_W-1:0] REM_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    coord_t             cur_x_q, cur_x_d;
    coord_t             cur_y_q, cur_y_d;
    err_t               dx_q, dx_d;       // +|dx|
    err_t               dy_q, dy_d;       // -|dy|
    logic               sx_neg_q, sx_neg_d;
    logic               sy_neg_q, sy_neg_d;
    err_t               err_q, err_d;
    logic [COORD_W-1:0] rem_q, rem_d;

    err_t ddx, ddy, abs_dx, abs_dy, e2;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        rem_d    = rem_q;

        ddx    = err_t'(x1) - err_t'(x0);
        ddy    = err_t'(y1) - err_t'(y0);
        abs_dx = ddx[ERR_W-1] ? -ddx : ddx;
        abs_dy = ddy[ERR_W-1] ? -ddy : ddy;
        e2     = err_q <<< 1;

        if (load) begin
            cur_x_d  = x0;
            cur_y_d  = y0;
            dx_d     = abs_dx;
            dy_d     = -abs_dy;
            // A zero delta steps negative; that axis never moves anyway.
            sx_neg_d = ddx[ERR_W-1] || (ddx == '0);
            sy_neg_d = ddy[ERR_W-1] || (ddy == '0);
            err_d    = abs_dx - abs_dy;
            rem_d    = (abs_dx > abs_dy) ? abs_dx[COORD_W-1:0] : abs_dy[COORD_W-1:0];
        end else if (advance && (rem_q != '0)) begin
            // Both decisions use the error value from before this step.
            if (e2 >= dy_q) begin
                err_d   = err_d + dy_q;
                cur_x_d = sx_neg_q ? (cur_x_q - C_ONE) : (cur_x_q + C_ONE);
            end
            if (e2 <= dx_q) begin
                err_d   = err_d + dx_q;
                cur_y_d = sy_neg_q ? (cur_y_q - C_ONE) : (cur_y_q + C_ONE);
            end
            rem_d = rem_q - REM_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            rem_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, independent of statement order.
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
            rem_q    <= rem_d;
        end
    end

    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;
    assign edge_end  = (rem_q == '0);
    assign last_step = (rem_q == REM_ONE);

endmodule

// File: rtl/hexagon_outline_gen.sv
// hexagon_outline_gen -- walks the outline of a pointy-top hexagon and emits
// its on-screen pixels over a valid/ready stream.
//
// Parameters:
//   HX_NUM, HX_SHIFT  half-width factor, hx = d*HX_NUM >> HX_SHIFT
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      request a walk (sampled in IDLE only)
//   xcenter, ycenter, d        centre and size unit (top vertex at yc+2d)
//   busy                       walk in progress
//   pix_valid, pix_ready       pixel handshake
//   pix_x, pix_y, pix_last     pixel coordinates, final-pixel marker
//   done                       one-cycle pulse at walk completion
//
// Vertices V0..V5 run clockwise from the top; edge k goes from Vk to
// V(k+1 mod 6), each edge excluding its end point so the closed outline
// emits every vertex exactly once.
module hexagon_outline_gen
    import hex_pkg::*;
#(
    parameter int HX_NUM   = HX_NUM_DEF,
    parameter int HX_SHIFT = HX_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] xcenter,
    input  logic [9:0] ycenter,
    input  logic [9:0] d,
    output logic       busy,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_last,
    output logic       done
);

    state_e     state_q, state_d;
    logic [9:0] xc_q, xc_d;
    logic [9:0] yc_q, yc_d;
    logic [9:0] d_q, d_d;
    logic [2:0] edge_q, edge_d;
    logic       zero_pend_q, zero_pend_d;   // d=0: the lone centre pixel is still owed
    logic       busy_q, busy_d;
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic       pix_last_q, pix_last_d;
    logic       done_q, done_d;

    coord_t vx_q [0:5];
    coord_t vy_q [0:5];
    coord_t vx_d [0:5];
    coord_t vy_d [0:5];
    logic   vtx_load;

    logic   st_load, st_adv, st_edge_end, st_last;
    coord_t st_cur_x, st_cur_y;
    logic [2:0] nxt_edge;
    logic   zero_len, on_screen;
    coord_t hx, xc, yc, dd, d2;

    // Vertex positions from the latched centre and size.
    always_comb begin
        hx = half_width(d_q, HX_NUM, HX_SHIFT);
        xc = coord_t'(xc_q);
        yc = coord_t'(yc_q);
        dd = coord_t'(d_q);
        d2 = dd <<< 1;
        vx_d[0] = xc;       vy_d[0] = yc + d2;
        vx_d[1] = xc + hx;  vy_d[1] = yc + dd;
        vx_d[2] = xc + hx;  vy_d[2] = yc - dd;
        vx_d[3] = xc;       vy_d[3] = yc - d2;
        vx_d[4] = xc - hx;  vy_d[4] = yc - dd;
        vx_d[5] = xc - hx;  vy_d[5] = yc + dd;
    end

    assign nxt_edge  = (edge_q == 3'd5) ? 3'd0 : (edge_q + 3'd1);
    assign zero_len  = (vx_q[edge_q] == vx_q[nxt_edge]) && (vy_q[edge_q] == vy_q[nxt_edge]);
    assign on_screen = (st_cur_x[COORD_W-1:10] == '0) && (st_cur_y[COORD_W-1:10] == '0);

    line_stepper u_stepper (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (st_load),
        .advance   (st_adv),
        .x0        (vx_q[edge_q]),
        .y0        (vy_q[edge_q]),
        .x1        (vx_q[nxt_edge]),
        .y1        (vy_q[nxt_edge]),
        .cur_x     (st_cur_x),
        .cur_y     (st_cur_y),
        .edge_end  (st_edge_end),
        .last_step (st_last)
    );

    always_comb begin
        state_d     = state_q;
        xc_d        = xc_q;
        yc_d        = yc_q;
        d_d         = d_q;
        edge_d      = edge_q;
        zero_pend_d = zero_pend_q;
        busy_d      = busy_q;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_last_d  = pix_last_q;
        done_d      = 1'b0;
        vtx_load    = 1'b0;
        st_load     = 1'b0;
        st_adv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    xc_d    = xcenter;
                    yc_d    = ycenter;
                    d_d     = d;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                vtx_load = 1'b1;
                // With d=0 every edge collapses; go straight to edge 5 and
                // emit the centre once from there so it can carry pix_last.
                zero_pend_d = (d_q == '0);
                edge_d      = (d_q == '0) ? 3'd5 : 3'd0;
                state_d     = SETUP;
            end

            SETUP: begin
                if (zero_len && !zero_pend_q) begin
                    if (edge_q == 3'd5) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        edge_d = nxt_edge;
                    end
                end else begin
                    st_load = 1'b1;
                    state_d = STEP;
                end
            end

            STEP: begin
                if (pix_valid_q) begin
                    // Hold the presented pixel until the consumer takes it.
                    if (pix_ready) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        if (zero_pend_q) begin
                            zero_pend_d = 1'b0;
                        end else begin
                            st_adv = 1'b1;
                        end
                    end
                end else if (!st_edge_end || zero_pend_q) begin
                    if (on_screen) begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = st_cur_x[9:0];
                        pix_y_d     = st_cur_y[9:0];
                        pix_last_d  = (edge_q == 3'd5) && (st_last || zero_pend_q);
                    end else begin
                        st_adv = 1'b1;   // clipped: skip without emitting
                    end
                end else if (edge_q == 3'd5) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    edge_d  = nxt_edge;
                    state_d = SETUP;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            xc_q        <= '0;
            yc_q        <= '0;
            d_q         <= '0;
            edge_q      <= '0;
            zero_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xc_q        <= xc_d;
            yc_q        <= yc_d;
            d_q         <= d_d;
            edge_q      <= edge_d;
            zero_pend_q <= zero_pend_d;
            busy_q      <= busy_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_last_q  <= pix_last_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the vertex table is pure datapath, always rewritten in LOAD before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (vtx_load) begin
            for (int i = 0; i < 6; i++) begin
                vx_q[i] <= vx_d[i];
                vy_q[i] <= vy_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_last  = pix_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hexagon_outline_gen.sv
// tb_hexagon_outline_gen -- scoreboard bench for hexagon_outline_gen.
//
// Stimulus pushes the hand-derived pixel list of each walk into a queue; a
// monitor pops and compares on every valid&&ready transfer and also checks
// that a stalled pixel stays put.
module tb_hexagon_outline_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] xcenter = '0;
    logic [9:0] ycenter = '0;
    logic [9:0] d = '0;
    logic       busy;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_last;
    logic       done;

    always #5 clk = ~clk;

    hexagon_outline_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .xcenter   (xcenter),
        .ycenter   (ycenter),
        .d         (d),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .done      (done)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       last;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_cnt = 0;
    int   done_cnt = 0;
    bit   rand_ready = 1'b0;

    // Outline for d=4 (hx=6) as offsets from the centre, edges V0->V1 ...
    // V5->V0, derived by hand with the integer line algorithm.
    int ox [40] = '{ 0,  1,  2,  3,  4,  5,
                     6,  6,  6,  6,  6,  6,  6,  6,
                     6,  5,  4,  3,  2,  1,
                     0, -1, -2, -3, -4, -5,
                    -6, -6, -6, -6, -6, -6, -6, -6,
                    -6, -5, -4, -3, -2, -1};
    int oy [40] = '{ 8,  7,  7,  6,  5,  5,
                     4,  3,  2,  1,  0, -1, -2, -3,
                    -4, -5, -5, -6, -7, -7,
                    -8, -7, -7, -6, -5, -5,
                    -4, -3, -2, -1,  0,  1,  2,  3,
                     4,  5,  5,  6,  7,  7};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_pix(input int px, input int py, input bit last);
        pix_t p;
        p.x    = 10'(px);
        p.y    = 10'(py);
        p.last = last;
        exp_q.push_back(p);
    endtask

    // Expected d=4 walk around (xc,yc), dropping off-screen pixels.
    task automatic push_walk(input int xc, input int yc);
        for (int i = 0; i < 40; i++) begin
            int px;
            int py;
            px = xc + ox[i];
            py = yc + oy[i];
            if (px >= 0 && px <= 1023 && py >= 0 && py <= 1023)
                push_pix(px, py, i == 39);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_last"},  pix_last,  0);
        check({tag, "_done"},      done,      0);
        check({tag, "_pix_x"},     pix_x,     0);
        check({tag, "_pix_y"},     pix_y,     0);
    endtask

    task automatic start_walk(input int xc, input int yc, input int dd);
        @(posedge clk);
        #1;
        xcenter = 10'(xc);
        ycenter = 10'(yc);
        d       = 10'(dd);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string name, input int budget, input int remaining);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done: no done pulse within %0d cycles", name, budget);
        end else begin
            check({name, "_busy_at_done"}, busy, 0);
            check({name, "_pixels_left"}, exp_q.size(), remaining);
            @(negedge clk);
            check({name, "_done_one_cycle"}, done, 0);
        end
    endtask

    // pix_ready driver: always-ready or random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        pix_t held;
        pix_t e;
        bit   holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (holding) begin
                    check("valid_held", pix_valid, 1);
                    if (pix_valid) check("data_stable", {pix_x, pix_y, pix_last}, held);
                end
                if (pix_valid) begin
                    if (pix_ready) begin
                        holding = 1'b0;
                        xfer_cnt++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pixel: actual=(%0d,%0d) required=none", pix_x, pix_y);
                        end else begin
                            e = exp_q.pop_front();
                            check("pix_x", pix_x, e.x);
                            check("pix_y", pix_y, e.y);
                            check("pix_last", pix_last, e.last);
                        end
                    end else begin
                        holding = 1'b1;
                        held    = {pix_x, pix_y, pix_last};
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  d0;
        int  x0;
        bit  found;

        // Reset state.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Nominal walk, always ready.
        rand_ready = 1'b0;
        push_walk(100, 100);
        start_walk(100, 100, 4);
        wait_done("walk_ready", 2000, 0);

        // Same walk with back-pressure.
        rand_ready = 1'b1;
        push_walk(100, 100);
        start_walk(100, 100, 4);
        wait_done("walk_stall", 4000, 0);

        // d=0: single centre pixel.
        push_pix(5, 7, 1'b1);
        start_walk(5, 7, 0);
        wait_done("d_zero", 200, 0);

        // Left-edge clipping.
        rand_ready = 1'b0;
        push_walk(2, 500);
        start_walk(2, 500, 4);
        wait_done("clip_left", 2000, 0);

        // Reset after the 10th transfer aborts the walk.
        push_walk(100, 100);
        base = xfer_cnt;
        start_walk(100, 100, 4);
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk);
            if (xfer_cnt >= base + 10) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL abort_wait: actual=%0d transfers required=10", xfer_cnt - base);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        x0 = xfer_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_pixels", xfer_cnt - x0, 0);
        check("abort_idle", busy, 0);
        push_walk(100, 100);
        start_walk(100, 100, 4);
        wait_done("after_abort", 2000, 0);

        // start held high: one walk, then the next only after done.
        push_walk(100, 100);
        push_walk(100, 100);
        @(posedge clk);
        #1;
        xcenter = 10'd100;
        ycenter = 10'd100;
        d       = 10'd4;
        start   = 1'b1;
        wait_done("held_first", 2000, 40);
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        start = 1'b0;
        wait_done("held_second", 2000, 0);
        repeat (10) @(negedge clk);
        check("held_no_third", busy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
